// File: rtl/ld19_packet_framer.sv
// LD19 packet framer: hunts for the header, buffers one scan packet, checks
// CRC-8 and streams the points out on a valid/ready interface.
//
// Ports:
//   sysclk, reset_n            clock, async active-low reset
//   byte_data/valid/error      byte stream from the UART receiver
//   pt_valid/ready             point stream handshake
//   pt_index/distance/intensity/last   current point record
//   speed/start_angle/end_angle/timestamp   header fields of last good packet
//   pkt_good, crc_fail         one-cycle status pulses
//   good_cnt, err_cnt          saturating statistics counters
module ld19_packet_framer #(
    parameter int unsigned NUM_POINTS  = 12,
    parameter logic [7:0]  HDR_BYTE    = 8'h54,
    parameter logic [7:0]  VERLEN_BYTE = 8'h2C,
    parameter logic [7:0]  CRC_POLY    = 8'h4D,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    input  logic             byte_error,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [3:0]       pt_index,
    output logic [15:0]      pt_distance,
    output logic [7:0]       pt_intensity,
    output logic             pt_last,
    output logic [15:0]      speed,
    output logic [15:0]      start_angle,
    output logic [15:0]      end_angle,
    output logic [15:0]      timestamp,
    output logic             pkt_good,
    output logic             crc_fail,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned PKT_LEN = 11 + 3 * NUM_POINTS;
    localparam int unsigned BW      = $clog2(PKT_LEN);

    localparam logic [BW-1:0] CRC_POS = BW'(PKT_LEN - 1);
    localparam logic [3:0]    LAST_PT = 4'(NUM_POINTS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_VERLEN,
        S_BODY,
        S_CHECK,
        S_EMIT
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       crc_q;
    logic             crc_ok_q;
    logic [BW-1:0]    cnt_q;
    logic [3:0]       idx_q;
    logic             drop_seen_q;
    logic [7:0]       pkt_mem [PKT_LEN];

    logic [15:0]      speed_q, start_q, end_q, ts_q;
    logic             pkt_good_q, crc_fail_q;
    logic [CNT_W-1:0] good_cnt_q, err_cnt_q;

    // Control strobes from the FSM to the datapath
    logic crc_init, crc_fold, cnt_init, store, crc_cmp;
    logic chk_pass, chk_fail, abort, drop, emit_adv;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        crc_init = 1'b0;
        crc_fold = 1'b0;
        cnt_init = 1'b0;
        store    = 1'b0;
        crc_cmp  = 1'b0;
        chk_pass = 1'b0;
        chk_fail = 1'b0;
        abort    = 1'b0;
        drop     = 1'b0;
        emit_adv = 1'b0;
        unique case (state_q)
            S_HUNT: begin
                // Errored bytes are simply ignored while hunting
                if (byte_valid && !byte_error && byte_data == HDR_BYTE) begin
                    state_d  = S_VERLEN;
                    crc_init = 1'b1;
                end
            end
            S_VERLEN: begin
                if (byte_valid) begin
                    if (byte_error) begin
                        abort   = 1'b1;
                        state_d = S_HUNT;
                    end else if (byte_data == VERLEN_BYTE) begin
                        // The version/length byte is covered by the CRC
                        crc_fold = 1'b1;
                        cnt_init = 1'b1;
                        state_d  = S_BODY;
                    end else if (byte_data == HDR_BYTE) begin
                        crc_init = 1'b1;
                    end else begin
                        state_d = S_HUNT;
                    end
                end
            end
            S_BODY: begin
                if (byte_valid) begin
                    if (byte_error) begin
                        abort   = 1'b1;
                        state_d = S_HUNT;
                    end else if (cnt_q == CRC_POS) begin
                        crc_cmp = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        store    = 1'b1;
                        crc_fold = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                drop = byte_valid && !drop_seen_q;
                if (crc_ok_q) begin
                    chk_pass = 1'b1;
                    state_d  = S_EMIT;
                end else begin
                    chk_fail = 1'b1;
                    state_d  = S_HUNT;
                end
            end
            S_EMIT: begin
                drop = byte_valid && !drop_seen_q;
                if (pt_ready) begin
                    if (idx_q == LAST_PT) begin
                        state_d = S_HUNT;
                    end else begin
                        emit_adv = 1'b1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    // Packet byte store; contents are only read while emitting a
    // validated packet, so it needs no reset.
    always_ff @(posedge sysclk) begin
        if (store) begin
            pkt_mem[cnt_q] <= byte_data;
        end
    end

    // Error increments can coincide (CRC failure plus a dropped byte)
    logic [1:0]     err_add;
    logic [CNT_W:0] err_sum;

    always_comb begin
        err_add = {1'b0, chk_fail} + {1'b0, abort} + {1'b0, drop};
        err_sum = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_add);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q       <= '0;
            crc_ok_q    <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            drop_seen_q <= 1'b0;
            speed_q     <= '0;
            start_q     <= '0;
            end_q       <= '0;
            ts_q        <= '0;
            pkt_good_q  <= 1'b0;
            crc_fail_q  <= 1'b0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            pkt_good_q <= chk_pass;
            crc_fail_q <= chk_fail;

            if (crc_init) begin
                crc_q <= crc8(8'h00, byte_data);
            end else if (crc_fold) begin
                crc_q <= crc8(crc_q, byte_data);
            end

            if (cnt_init) begin
                cnt_q <= BW'(2);
            end else if (store) begin
                cnt_q <= cnt_q + BW'(1);
            end

            if (crc_cmp) begin
                crc_ok_q    <= (byte_data == crc_q);
                drop_seen_q <= 1'b0;
            end else if (drop) begin
                drop_seen_q <= 1'b1;
            end

            if (chk_pass) begin
                idx_q   <= '0;
                speed_q <= {pkt_mem[3], pkt_mem[2]};
                start_q <= {pkt_mem[5], pkt_mem[4]};
                end_q   <= {pkt_mem[PKT_LEN-4], pkt_mem[PKT_LEN-5]};
                ts_q    <= {pkt_mem[PKT_LEN-2], pkt_mem[PKT_LEN-3]};
                if (good_cnt_q != '1) begin
                    good_cnt_q <= good_cnt_q + CNT_W'(1);
                end
            end else if (emit_adv) begin
                idx_q <= idx_q + 4'd1;
            end

            if (err_add != 2'd0) begin
                err_cnt_q <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            end
        end
    end

    // Point k starts at byte 6+3k: distance low, distance high, intensity
    logic [BW-1:0] pt_base;

    assign pt_base = BW'(6) + BW'(3) * BW'(idx_q);

    always_comb begin
        pt_valid     = (state_q == S_EMIT);
        pt_index     = '0;
        pt_distance  = '0;
        pt_intensity = '0;
        pt_last      = 1'b0;
        if (pt_valid) begin
            pt_index     = idx_q;
            pt_distance  = {pkt_mem[pt_base + BW'(1)], pkt_mem[pt_base]};
            pt_intensity = pkt_mem[pt_base + BW'(2)];
            pt_last      = (idx_q == LAST_PT);
        end
    end

    assign speed       = speed_q;
    assign start_angle = start_q;
    assign end_angle   = end_q;
    assign timestamp   = ts_q;
    assign pkt_good    = pkt_good_q;
    assign crc_fail    = crc_fail_q;
    assign good_cnt    = good_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ld19_packet_framer.sv
// Directed testbench for ld19_packet_framer.
// Drives LD19 byte streams and checks framing, CRC, stream and counters.
module tb_ld19_packet_framer;

    localparam int NP = 12;
    localparam int PL = 11 + 3 * NP;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_error = 1'b0;
    logic        pt_ready = 1'b0;
    logic        pt_valid;
    logic [3:0]  pt_index;
    logic [15:0] pt_distance;
    logic [7:0]  pt_intensity;
    logic        pt_last;
    logic [15:0] speed, start_angle, end_angle, timestamp;
    logic        pkt_good, crc_fail;
    logic [15:0] good_cnt, err_cnt;

    ld19_packet_framer dut (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_error  (byte_error),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_index    (pt_index),
        .pt_distance (pt_distance),
        .pt_intensity(pt_intensity),
        .pt_last     (pt_last),
        .speed       (speed),
        .start_angle (start_angle),
        .end_angle   (end_angle),
        .timestamp   (timestamp),
        .pkt_good    (pkt_good),
        .crc_fail    (crc_fail),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pkt [PL];

    // Observation side: records handshakes and pulses on the falling edge
    int cyc = 0;
    int hs_cnt = 0, good_pulses = 0, fail_pulses = 0;
    int valid_cycles = 0, stab_err = 0;
    int rec_idx[$], rec_dist[$], rec_int[$], rec_last[$], rec_cyc[$];
    logic        hold_q = 1'b0;
    logic [28:0] hold_v = '0;

    always @(posedge sysclk) cyc++;

    always @(negedge sysclk) begin
        if (pkt_good) good_pulses++;
        if (crc_fail) fail_pulses++;
        if (pt_valid) valid_cycles++;
        if (hold_q && pt_valid &&
            {pt_index, pt_distance, pt_intensity, pt_last} !== hold_v)
            stab_err++;
        if (pt_valid && pt_ready) begin
            rec_idx.push_back(int'(pt_index));
            rec_dist.push_back(int'(pt_distance));
            rec_int.push_back(int'(pt_intensity));
            rec_last.push_back(int'(pt_last));
            rec_cyc.push_back(cyc);
            hs_cnt++;
        end
        hold_q = pt_valid && !pt_ready;
        hold_v = {pt_index, pt_distance, pt_intensity, pt_last};
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h4D) : (r << 1);
        return r;
    endfunction

    task automatic build(input logic [15:0] spd, input logic [15:0] st,
                         input logic [15:0] en, input logic [15:0] ts,
                         input logic [15:0] d0, input logic [15:0] dstep,
                         input logic [7:0] i0, input logic [7:0] istep);
        logic [7:0]  c;
        logic [15:0] d;
        logic [7:0]  it;
        pkt[0] = 8'h54;
        pkt[1] = 8'h2C;
        pkt[2] = spd[7:0];
        pkt[3] = spd[15:8];
        pkt[4] = st[7:0];
        pkt[5] = st[15:8];
        for (int k = 0; k < NP; k++) begin
            d  = d0 + dstep * 16'(k);
            it = i0 + istep * 8'(k);
            pkt[6 + 3 * k] = d[7:0];
            pkt[7 + 3 * k] = d[15:8];
            pkt[8 + 3 * k] = it;
        end
        pkt[PL - 5] = en[7:0];
        pkt[PL - 4] = en[15:8];
        pkt[PL - 3] = ts[7:0];
        pkt[PL - 2] = ts[15:8];
        c = 8'h00;
        for (int i = 0; i < PL - 1; i++) c = crc8(c, pkt[i]);
        pkt[PL - 1] = c;
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        byte_data  = b;
        byte_valid = 1'b1;
        byte_error = e;
        tick();
        byte_valid = 1'b0;
        byte_error = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(pkt[i], 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!pt_valid && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(pt_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (pt_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(pt_valid), 32'd0);
    endtask

    // Compare the 12 handshakes recorded from position base onwards
    task automatic verify_pts(input string tag, input int base,
                              input logic [15:0] d0, input logic [15:0] dstep,
                              input logic [7:0] i0, input logic [7:0] istep);
        int bad_i, bad_d, bad_n, bad_l;
        logic [15:0] d;
        logic [7:0]  it;
        bad_i = 0; bad_d = 0; bad_n = 0; bad_l = 0;
        check({tag, "_hs"}, 32'(hs_cnt - base), 32'd12);
        for (int k = 0; k < NP && base + k < hs_cnt; k++) begin
            d  = d0 + dstep * 16'(k);
            it = i0 + istep * 8'(k);
            if (rec_idx[base + k] != k) bad_i++;
            if (rec_dist[base + k] != int'(d)) bad_d++;
            if (rec_int[base + k] != int'(it)) bad_n++;
            if (rec_last[base + k] != int'(k == NP - 1)) bad_l++;
        end
        check({tag, "_index"}, 32'(bad_i), 32'd0);
        check({tag, "_dist"}, 32'(bad_d), 32'd0);
        check({tag, "_int"}, 32'(bad_n), 32'd0);
        check({tag, "_last"}, 32'(bad_l), 32'd0);
    endtask

    int b, vc, gp, fp;

    initial begin
        // Reset
        tick();
        tick();
        check("rst_valid", 32'(pt_valid), 32'd0);
        check("rst_speed", 32'(speed), 32'd0);
        check("rst_good", 32'(good_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_dist", 32'(pt_distance), 32'd0);
        reset_n = 1'b1;
        tick();

        // T1 good packet, back-to-back bytes
        pt_ready = 1'b1;
        build(16'h0E10, 16'h1234, 16'h5678, 16'h0ABC, 16'h01F4, 16'h0, 8'hC8, 8'h0);
        b = hs_cnt;
        send_range(0, PL - 1);
        check("t1_check_novalid", 32'(pt_valid), 32'd0);
        tick();
        check("t1_first_valid", 32'(pt_valid), 32'd1);
        check("t1_pkt_good", 32'(pkt_good), 32'd1);
        check("t1_speed", 32'(speed), 32'h0E10);
        tick();
        check("t1_pulse_once", 32'(pkt_good), 32'd0);
        wait_idle("t1_idle");
        verify_pts("t1", b, 16'h01F4, 16'h0, 8'hC8, 8'h0);
        check("t1_start", 32'(start_angle), 32'h1234);
        check("t1_end", 32'(end_angle), 32'h5678);
        check("t1_ts", 32'(timestamp), 32'h0ABC);
        check("t1_good_cnt", 32'(good_cnt), 32'd1);
        check("t1_good_pulses", 32'(good_pulses), 32'd1);

        // T2 corrupted CRC
        build(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h01F4, 16'h0, 8'hC8, 8'h0);
        pkt[PL - 1] = pkt[PL - 1] ^ 8'h01;
        vc = valid_cycles;
        send_range(0, PL - 1);
        tick();
        check("t2_crc_fail", 32'(crc_fail), 32'd1);
        check("t2_no_good", 32'(pkt_good), 32'd0);
        tick();
        tick();
        check("t2_err_cnt", 32'(err_cnt), 32'd1);
        check("t2_fail_pulses", 32'(fail_pulses), 32'd1);
        check("t2_no_valid", 32'(valid_cycles - vc), 32'd0);
        check("t2_speed_kept", 32'(speed), 32'h0E10);
        check("t2_ts_kept", 32'(timestamp), 32'h0ABC);
        check("t2_good_cnt", 32'(good_cnt), 32'd1);

        // T3a junk 54 54 2C then a good body
        build(16'h2222, 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0001, 8'h10, 8'h01);
        b = hs_cnt;
        send(8'h54, 1'b0);
        send_range(0, PL - 1);
        wait_valid("t3a_valid");
        wait_idle("t3a_idle");
        verify_pts("t3a", b, 16'h0100, 16'h0001, 8'h10, 8'h01);
        check("t3a_good_cnt", 32'(good_cnt), 32'd2);
        check("t3a_speed", 32'(speed), 32'h2222);

        // T3b junk 54 00 then a good packet
        build(16'h3333, 16'h0, 16'h0, 16'h0, 16'h0A0B, 16'h0010, 8'h20, 8'h02);
        send(8'h54, 1'b0);
        send(8'h00, 1'b0);
        send_range(0, PL - 1);
        wait_valid("t3b_valid");
        wait_idle("t3b_idle");
        check("t3b_good_cnt", 32'(good_cnt), 32'd3);
        check("t3b_speed", 32'(speed), 32'h3333);
        check("t3b_err_cnt", 32'(err_cnt), 32'd1);

        // T4 backpressure at index 3
        pt_ready = 1'b0;
        build(16'h4444, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0003, 8'h40, 8'h05);
        b = hs_cnt;
        send_range(0, PL - 1);
        wait_valid("t4_valid");
        pt_ready = 1'b1;
        tick();
        tick();
        tick();
        pt_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t4_hold_index", 32'(pt_index), 32'd3);
        check("t4_hold_valid", 32'(pt_valid), 32'd1);
        check("t4_hold_dist", 32'(pt_distance), 32'h0209);
        check("t4_hold_int", 32'(pt_intensity), 32'h4F);
        check("t4_hold_last", 32'(pt_last), 32'd0);
        check("t4_stable", 32'(stab_err), 32'd0);
        pt_ready = 1'b1;
        wait_idle("t4_idle");
        verify_pts("t4", b, 16'h0200, 16'h0003, 8'h40, 8'h05);
        check("t4_b2b", 32'(rec_cyc[b + 11] - rec_cyc[b + 4]), 32'd7);
        check("t4_good_cnt", 32'(good_cnt), 32'd4);

        // T5 byte_error on byte 10, then a good packet
        gp = good_pulses;
        send_range(0, 9);
        send(pkt[10], 1'b1);
        check("t5_err_cnt", 32'(err_cnt), 32'd2);
        build(16'h5555, 16'h0, 16'h0, 16'h0, 16'h0300, 16'h0, 8'h11, 8'h0);
        send_range(0, PL - 1);
        wait_valid("t5_valid");
        wait_idle("t5_idle");
        check("t5_good_cnt", 32'(good_cnt), 32'd5);
        check("t5_pulses", 32'(good_pulses - gp), 32'd1);
        check("t5_speed", 32'(speed), 32'h5555);

        // T5b bytes arriving during EMIT count one error
        pt_ready = 1'b0;
        build(16'h6666, 16'h0, 16'h0, 16'h0, 16'h0400, 16'h0, 8'h22, 8'h0);
        send_range(0, PL - 1);
        wait_valid("t5b_valid");
        send(8'h54, 1'b0);
        send(8'h2C, 1'b0);
        check("t5b_err_once", 32'(err_cnt), 32'd3);
        pt_ready = 1'b1;
        wait_idle("t5b_idle");
        build(16'h7777, 16'h0, 16'h0, 16'h0, 16'h0500, 16'h0, 8'h33, 8'h0);
        send_range(0, PL - 1);
        wait_valid("t5b_rehunt");
        wait_idle("t5b_idle2");
        check("t5b_good_cnt", 32'(good_cnt), 32'd7);

        // T6 reset mid-BODY
        send_range(0, 19);
        reset_n = 1'b0;
        #1;
        check("t6a_good", 32'(good_cnt), 32'd0);
        check("t6a_err", 32'(err_cnt), 32'd0);
        check("t6a_speed", 32'(speed), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        send_range(0, PL - 1);
        wait_valid("t6a_valid");
        wait_idle("t6a_idle");
        check("t6a_good_after", 32'(good_cnt), 32'd1);

        // T6 reset mid-EMIT
        pt_ready = 1'b0;
        send_range(0, PL - 1);
        wait_valid("t6b_valid");
        reset_n = 1'b0;
        #1;
        check("t6b_valid", 32'(pt_valid), 32'd0);
        check("t6b_dist", 32'(pt_distance), 32'd0);
        check("t6b_good", 32'(good_cnt), 32'd0);
        check("t6b_speed", 32'(speed), 32'd0);
        tick();
        reset_n = 1'b1;
        pt_ready = 1'b1;
        tick();
        fp = fail_pulses;
        build(16'h8888, 16'h0, 16'h0, 16'h0, 16'h0600, 16'h0002, 8'h44, 8'h03);
        b = hs_cnt;
        send_range(0, PL - 1);
        wait_valid("t6b_valid2");
        wait_idle("t6b_idle");
        verify_pts("t6b", b, 16'h0600, 16'h0002, 8'h44, 8'h03);
        check("t6b_good_after", 32'(good_cnt), 32'd1);
        check("t6b_err_after", 32'(err_cnt), 32'd0);
        check("t6b_no_fail", 32'(fail_pulses - fp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
